// File: rtl/instruction_register_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_register_pkg
// Brief    : Shared encodings for the instruction register and its neighbours.
// Revision : 1.0
// ============================================================================
package instruction_register_pkg;

    typedef enum logic [1:0] {
        INT_NONE  = 2'd0,
        INT_IRQ   = 2'd1,
        INT_NMI   = 2'd2,
        INT_RESET = 2'd3
    } int_kind_t;

    localparam logic [7:0] BRK_OPCODE  = 8'h00;
    localparam logic [2:0] T_STATE_MAX = 3'd7;

    function automatic logic [2:0] t_state_inc(input logic [2:0] t);
        return (t == T_STATE_MAX) ? t : t + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_register_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_register_if
// Brief    : Fetch-side bus and decoder-side outputs of the instruction register.
// Revision : 1.0
// ============================================================================
interface instruction_register_if
    import instruction_register_pkg::*;
();
    logic [7:0] data_in;
    logic       fetch;
    logic       rdy;
    logic       nmi;
    logic       irq;
    logic       i_flag;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic [2:0] t_state;
    int_kind_t  int_kind;
    logic       pc_inc_inhibit;

    modport master (
        output data_in, fetch, rdy, nmi, irq, i_flag,
        input  opcode, opcode_valid, t_state, int_kind, pc_inc_inhibit
    );

    modport slave (
        input  data_in, fetch, rdy, nmi, irq, i_flag,
        output opcode, opcode_valid, t_state, int_kind, pc_inc_inhibit
    );
endinterface
`default_nettype wire

// File: rtl/instruction_register_nmi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : nmi_edge_detect
// Brief    : Rising-edge NMI capture; a new edge beats a same-cycle clear.
// Revision : 1.0
// ============================================================================
module nmi_edge_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic nmi,
    input  wire logic clear,
    output logic      pending
);
    logic r_nmi_prev;
    logic r_nmi_pend;
    logic w_rise;

    assign w_rise = nmi & ~r_nmi_prev;

    // Runs independently of rdy so edges during wait states are never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_prev <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_prev <= nmi;
            if (w_rise) begin
                r_nmi_pend <= 1'b1;
            end else if (clear) begin
                r_nmi_pend <= 1'b0;
            end
        end
    end

    assign pending = r_nmi_pend;
endmodule
`default_nettype wire

// File: rtl/instruction_register.sv
`default_nettype none
// ============================================================================
// Module   : instruction_register
// Brief    : Opcode latch with BRK injection for RESET/NMI/IRQ and T-state counter.
// Revision : 1.0
// ============================================================================
module instruction_register
    import instruction_register_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    instruction_register_if.slave  bus
);
    logic [7:0] r_opcode;
    logic       r_opcode_valid;
    logic [2:0] r_t_state;
    int_kind_t  r_int_kind;
    logic       r_pc_inc_inhibit;
    logic       r_reset_pend;

    logic       w_accept;
    logic       w_nmi_pend;
    logic       w_nmi_clear;
    logic [7:0] w_sel_opcode;
    int_kind_t  w_sel_kind;

    assign w_accept = bus.fetch & bus.rdy;

    // Source priority uses only state registered before this cycle.
    always_comb begin
        w_sel_opcode = bus.data_in;
        w_sel_kind   = INT_NONE;
        if (r_reset_pend) begin
            w_sel_opcode = BRK_OPCODE;
            w_sel_kind   = INT_RESET;
        end else if (w_nmi_pend) begin
            w_sel_opcode = BRK_OPCODE;
            w_sel_kind   = INT_NMI;
        end else if (bus.irq & ~bus.i_flag) begin
            w_sel_opcode = BRK_OPCODE;
            w_sel_kind   = INT_IRQ;
        end
    end

    assign w_nmi_clear = w_accept & ~r_reset_pend & w_nmi_pend;

    nmi_edge_detect u_nmi_edge_detect (
        .clk     (clk),
        .rst     (rst),
        .nmi     (bus.nmi),
        .clear   (w_nmi_clear),
        .pending (w_nmi_pend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode         <= BRK_OPCODE;
            r_opcode_valid   <= 1'b0;
            r_t_state        <= 3'd0;
            r_int_kind       <= INT_NONE;
            r_pc_inc_inhibit <= 1'b0;
            r_reset_pend     <= 1'b1;
        end else if (w_accept) begin
            r_opcode         <= w_sel_opcode;
            r_opcode_valid   <= 1'b1;
            r_t_state        <= 3'd1;
            r_int_kind       <= w_sel_kind;
            r_pc_inc_inhibit <= (w_sel_kind != INT_NONE);
            r_reset_pend     <= 1'b0;
        end else if (bus.rdy) begin
            r_t_state        <= t_state_inc(r_t_state);
        end
    end

    assign bus.opcode         = r_opcode;
    assign bus.opcode_valid   = r_opcode_valid;
    assign bus.t_state        = r_t_state;
    assign bus.int_kind       = r_int_kind;
    assign bus.pc_inc_inhibit = r_pc_inc_inhibit;
endmodule
`default_nettype wire

// File: tb/tb_instruction_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_register
// Brief    : Directed scoreboard bench for the instruction register.
// Revision : 1.0
// ============================================================================
module tb_instruction_register;
    import instruction_register_pkg::*;

    typedef struct {
        logic [7:0] op;
        int_kind_t  kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    instruction_register_if bus ();

    instruction_register dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_op(input string tag, input logic [7:0] d,
                            input logic [7:0] eop, input int_kind_t ek);
        exp_t e;
        exp_t got;
        bus.data_in = d;
        bus.fetch   = 1'b1;
        bus.rdy     = 1'b1;
        e.op   = eop;
        e.kind = ek;
        sb.push_back(e);
        tick();
        bus.fetch = 1'b0;
        got = sb.pop_front();
        check({tag, ".opcode"}, bus.opcode, got.op);
        check({tag, ".int_kind"}, 8'(bus.int_kind), 8'(got.kind));
        check({tag, ".pc_inc_inhibit"}, 8'(bus.pc_inc_inhibit), (got.kind != INT_NONE) ? 8'd1 : 8'd0);
        check({tag, ".opcode_valid"}, 8'(bus.opcode_valid), 8'd1);
        check({tag, ".t_state"}, 8'(bus.t_state), 8'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".opcode"}, bus.opcode, 8'h00);
        check({tag, ".opcode_valid"}, 8'(bus.opcode_valid), 8'd0);
        check({tag, ".t_state"}, 8'(bus.t_state), 8'd0);
        check({tag, ".int_kind"}, 8'(bus.int_kind), 8'(INT_NONE));
        check({tag, ".pc_inc_inhibit"}, 8'(bus.pc_inc_inhibit), 8'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.data_in = 8'h00;
        bus.fetch   = 1'b0;
        bus.rdy     = 1'b1;
        bus.nmi     = 1'b0;
        bus.irq     = 1'b0;
        bus.i_flag  = 1'b0;
        repeat (2) tick();
        check_reset_state("reset");
        rst = 1'b0;

        // First fetch after reset always injects RESET.
        fetch_op("reset_fetch", 8'hA9, 8'h00, INT_RESET);

        for (int i = 2; i <= 10; i++) begin
            tick();
            check($sformatf("t_sat_%0d", i), 8'(bus.t_state), (i > 7) ? 8'd7 : 8'(i));
        end

        bus.rdy     = 1'b0;
        bus.fetch   = 1'b1;
        bus.data_in = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_op_%0d", i), bus.opcode, 8'h00);
            check($sformatf("stall_t_%0d", i), 8'(bus.t_state), 8'd7);
        end
        bus.fetch = 1'b0;
        bus.rdy   = 1'b1;

        fetch_op("plain_a9", 8'hA9, 8'hA9, INT_NONE);

        bus.irq    = 1'b1;
        bus.i_flag = 1'b1;
        fetch_op("irq_masked", 8'h4C, 8'h4C, INT_NONE);
        bus.i_flag = 1'b0;
        fetch_op("irq_taken", 8'h4C, 8'h00, INT_IRQ);

        // NMI edge captured during a wait state, beats pending IRQ.
        bus.rdy = 1'b0;
        bus.nmi = 1'b1;
        tick();
        bus.nmi = 1'b0;
        tick();
        fetch_op("nmi_over_irq", 8'hEA, 8'h00, INT_NMI);
        bus.irq = 1'b0;
        fetch_op("after_nmi", 8'hEA, 8'hEA, INT_NONE);

        bus.nmi = 1'b1;
        tick();
        bus.nmi = 1'b0;
        tick();
        bus.nmi = 1'b1;
        fetch_op("nmi_setwins_1", 8'h11, 8'h00, INT_NMI);
        bus.nmi = 1'b0;
        fetch_op("nmi_setwins_2", 8'h11, 8'h00, INT_NMI);
        fetch_op("nmi_drained", 8'h11, 8'h11, INT_NONE);

        fetch_op("pre_reset", 8'h22, 8'h22, INT_NONE);
        repeat (2) tick();
        check("mid_t_state", 8'(bus.t_state), 8'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        tick();
        rst = 1'b0;
        bus.irq    = 1'b1;
        bus.i_flag = 1'b0;
        fetch_op("rearm_reset", 8'h33, 8'h00, INT_RESET);
        bus.irq = 1'b0;

        check("scoreboard_empty", 8'(sb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
